// File: rtl/median_result_writer_pkg.sv
// Shared filter constants, FSM states and the write-request record used by the
// median result writer.
package median_result_writer_pkg;

  localparam int IMAGE_WIDTH   = 240;
  localparam int IMAGE_HEIGHT  = 180;
  localparam int WINDOW_SIZE   = 3;
  localparam int OUT_W         = IMAGE_WIDTH - WINDOW_SIZE + 1;
  localparam int OUT_H         = IMAGE_HEIGHT - WINDOW_SIZE + 1;
  localparam int TOTAL_RESULTS = OUT_W * OUT_H;
  localparam int NUM_BYTES     = (TOTAL_RESULTS + 7) / 8;
  localparam int ADDR_W        = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_req_t;

endpackage

// File: rtl/median_result_writer_bit_packer.sv
// Collects one result bit per strobe into a byte, LSB first; flags the 8th bit.
module bit_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shiftEn,
  input  logic       bitIn,
  output logic [7:0] byteOut,
  output logic       byteDone,
  output logic [7:0] partial
);

  logic [7:0] packReg;
  logic [2:0] bitCnt;

  // byteOut is the byte including this cycle's bit, so a completed byte can
  // be captured on the same edge that takes its last bit.
  always_comb begin
    byteOut         = packReg;
    byteOut[bitCnt] = bitIn;
    byteDone        = shiftEn && (bitCnt == 3'd7);
  end

  assign partial = packReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      packReg <= '0;
      bitCnt  <= '0;
    end else if (clear) begin
      packReg <= '0;
      bitCnt  <= '0;
    end else if (shiftEn) begin
      packReg <= byteDone ? 8'h00 : byteOut;
      bitCnt  <= bitCnt + 3'd1;
    end
  end

endmodule

// File: rtl/median_result_writer.sv
// Packs median filter results column-major into bytes and issues byte writes
// through a single holding register with ready/enable handshake.
module median_result_writer
  import median_result_writer_pkg::*;
#(
  parameter int IMAGEWIDTH  = IMAGE_WIDTH,
  parameter int IMAGEHEIGHT = IMAGE_HEIGHT,
  parameter int WINDOWSIZE  = WINDOW_SIZE,
  parameter int OUTW        = IMAGEWIDTH - WINDOWSIZE + 1,
  parameter int OUTH        = IMAGEHEIGHT - WINDOWSIZE + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              medianValid,
  input  logic              medianData,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [7:0]        wrData,
  input  logic              wrReady,
  output logic [7:0]        xOut,
  output logic [7:0]        yOut,
  output logic              writeDone,
  output logic              overflowErr
);

  localparam int         TOTAL = OUTW * OUTH;
  localparam bit         PAD   = (TOTAL % 8) != 0;
  localparam logic [7:0] XLAST = 8'(OUTW - 1);
  localparam logic [7:0] YLAST = 8'(OUTH - 1);

  wr_state_t         state, nextState;
  wr_req_t           hold;
  logic [ADDR_W-1:0] byteIdx;
  logic              padPending;
  logic              take, lastTake, accept, canLoad, byteDone;
  logic [7:0]        packedByte, partialByte;

  assign take     = (state == RUN) && medianValid;
  assign lastTake = take && (xOut == XLAST) && (yOut == YLAST);
  assign accept   = wrEn && wrReady;
  assign canLoad  = !wrEn || wrReady;

  assign wrAddr    = hold.addr;
  assign wrData    = hold.data;
  assign writeDone = (state == DONE);

  bit_packer uPacker (
    .clk      (clk),
    .reset    (reset),
    .clear    (!start),
    .shiftEn  (take),
    .bitIn    (medianData),
    .byteOut  (packedByte),
    .byteDone (byteDone),
    .partial  (partialByte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (lastTake) nextState = FLUSH;
      // Done once nothing remains to pad and the holding register drains.
      FLUSH:   if (!padPending && canLoad) nextState = DONE;
      DONE:    nextState = DONE;
      default: nextState = IDLE;
    endcase
    if (!start) nextState = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xOut        <= '0;
      yOut        <= '0;
      byteIdx     <= '0;
      wrEn        <= 1'b0;
      hold        <= '0;
      overflowErr <= 1'b0;
      padPending  <= 1'b0;
    end else if (!start) begin
      xOut        <= '0;
      yOut        <= '0;
      byteIdx     <= '0;
      wrEn        <= 1'b0;
      hold        <= '0;
      overflowErr <= 1'b0;
      padPending  <= 1'b0;
    end else begin
      if (accept) wrEn <= 1'b0;

      // Coordinates park on the last result instead of wrapping past the frame.
      if (take && !lastTake) begin
        if (yOut == YLAST) begin
          yOut <= '0;
          xOut <= xOut + 8'd1;
        end else begin
          yOut <= yOut + 8'd1;
        end
      end

      if (lastTake) padPending <= PAD;

      // The byte index advances even when the byte is dropped, keeping later
      // addresses aligned with their result positions.
      if (byteDone) begin
        byteIdx <= byteIdx + ADDR_W'(1);
        if (canLoad) begin
          wrEn      <= 1'b1;
          hold.addr <= byteIdx;
          hold.data <= packedByte;
        end else begin
          overflowErr <= 1'b1;
        end
      end

      if ((state == FLUSH) && padPending && canLoad) begin
        wrEn       <= 1'b1;
        hold.addr  <= byteIdx;
        hold.data  <= partialByte;
        padPending <= 1'b0;
      end
    end
  end

endmodule
